// File: rtl/stepper_pattern_player.sv
// Latches a sequence of 4-bit coil patterns and plays it to the H-bridge drivers.
// Each entry is held STEP_CYCLES, with an all-off dead-time between differing entries.
module stepper_pattern_player #(
    parameter int N_STEPS     = 30,
    parameter int STEP_CYCLES = 1000,
    parameter int DEAD_CYCLES = 4
) (
    input  logic                   system1000,
    input  logic                   system1000_rst,
    input  logic                   pat_valid,
    input  logic [4*N_STEPS-1:0]   pat_bus,
    input  logic                   run,
    output logic [3:0]             coil,
    output logic                   busy,
    output logic [4:0]             step_idx,
    output logic                   done
);

    localparam int CNT_MAX = (STEP_CYCLES > DEAD_CYCLES) ? STEP_CYCLES : DEAD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [4:0]       IDX_LAST  = 5'(N_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DEAD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       coil_q, coil_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             capture;
    logic [4:0]       idx_inc;

    logic [3:0] bus_entry [N_STEPS];
    logic [3:0] store_q   [N_STEPS];

    // Entry 0 sits in the most significant nibble of the flat bus.
    genvar gi;
    generate
        for (gi = 0; gi < N_STEPS; gi++) begin : g_store
            assign bus_entry[gi] = pat_bus[4*(N_STEPS-1-gi) +: 4];

            always_ff @(posedge system1000 or posedge system1000_rst) begin
                if (system1000_rst) begin
                    store_q[gi] <= 4'd0;
                end else if (capture) begin
                    store_q[gi] <= bus_entry[gi];
                end
            end
        end
    endgenerate

    assign idx_inc = idx_q + 5'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        capture = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pat_valid) begin
                    capture = 1'b1;
                    idx_d   = 5'd0;
                    cnt_d   = '0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (run) begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d = idx_inc;
                            if ((DEAD_CYCLES > 0) && (store_q[idx_inc] != store_q[idx_q])) begin
                                state_d = S_DEAD;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DEAD: begin
                if (run) begin
                    if (cnt_q == DEAD_LAST) begin
                        cnt_d   = '0;
                        state_d = S_DRIVE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state; on capture the store is not yet
    // loaded, so the first entry comes straight from the bus.
    always_comb begin
        coil_d = 4'd0;
        if (state_d == S_DRIVE) begin
            coil_d = capture ? bus_entry[0] : store_q[idx_d];
        end
        busy_d = (state_d == S_DRIVE) || (state_d == S_DEAD);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd0;
            cnt_q   <= '0;
            coil_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            coil_q  <= coil_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign coil     = coil_q;
    assign busy     = busy_q;
    assign step_idx = idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_stepper_pattern_player.sv
// Randomized bench for stepper_pattern_player against a segment-queue playback model.
module tb_stepper_pattern_player;

    localparam int N  = 30;
    localparam int SC = 3;
    localparam int DC = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           pat_valid;
    logic [4*N-1:0] pat_bus;
    logic           run;
    logic [3:0]     coil;
    logic           busy;
    logic [4:0]     step_idx;
    logic           done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    stepper_pattern_player #(
        .N_STEPS    (N),
        .STEP_CYCLES(SC),
        .DEAD_CYCLES(DC)
    ) dut (
        .system1000    (clk),
        .system1000_rst(rst),
        .pat_valid     (pat_valid),
        .pat_bus       (pat_bus),
        .run           (run),
        .coil          (coil),
        .busy          (busy),
        .step_idx      (step_idx),
        .done          (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Playback is a queue of timed segments (one per entry plus one per gap),
    // consumed one unit per run-enabled clock edge.
    typedef struct {
        logic [3:0] c;
        int         idx;
        int         len;
    } seg_t;

    seg_t       segq[$];
    int         m_left;
    bit         m_done;
    logic [3:0] exp_coil;
    bit         exp_busy;
    bit         exp_done;
    int         exp_idx;

    logic           s_pv;
    logic [4*N-1:0] s_bus;
    logic           s_run;

    always @(posedge clk) begin
        s_pv  <= pat_valid;
        s_bus <= pat_bus;
        s_run <= run;
    end

    task automatic model_load(input logic [4*N-1:0] b);
        seg_t s;
        segq.delete();
        for (int i = 0; i < N; i++) begin
            s.c   = b[4*(N-1-i) +: 4];
            s.idx = i;
            s.len = SC;
            segq.push_back(s);
            if (i < N-1 && DC > 0 && b[4*(N-2-i) +: 4] != b[4*(N-1-i) +: 4]) begin
                s.c   = 4'd0;
                s.idx = i + 1;
                s.len = DC;
                segq.push_back(s);
            end
        end
        m_left = SC;
    endtask

    task automatic model_step(input logic pv, input logic [4*N-1:0] b, input logic r);
        if (m_done) begin
            m_done = 1'b0;
        end else if (segq.size() == 0) begin
            if (pv) model_load(b);
        end else if (r) begin
            m_left--;
            if (m_left == 0) begin
                void'(segq.pop_front());
                if (segq.size() == 0) m_done = 1'b1;
                else m_left = segq[0].len;
            end
        end
        if (segq.size() > 0) begin
            exp_coil = segq[0].c;
            exp_busy = 1'b1;
            exp_idx  = segq[0].idx;
        end else begin
            exp_coil = 4'd0;
            exp_busy = 1'b0;
        end
        exp_done = m_done;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            segq.delete();
            m_done   = 1'b0;
            exp_coil = 4'd0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_idx  = 0;
        end else begin
            model_step(s_pv, s_bus, s_run);
            if (chk_en) begin
                chk("coil", 32'(coil), 32'(exp_coil));
                chk("busy", 32'(busy), 32'(exp_busy));
                chk("done", 32'(done), 32'(exp_done));
                if (exp_busy) chk("step_idx", 32'(step_idx), 32'(exp_idx));
            end
        end
    end

    function automatic logic [4*N-1:0] wave_bus();
        logic [4*N-1:0] b;
        for (int i = 0; i < N; i++) b[4*(N-1-i) +: 4] = 4'(1 << (i % 4));
        return b;
    endfunction

    function automatic logic [4*N-1:0] const_bus(input logic [3:0] v);
        logic [4*N-1:0] b;
        for (int i = 0; i < N; i++) b[4*(N-1-i) +: 4] = v;
        return b;
    endfunction

    // Small alphabet so equal neighbours (no gap) and zero entries both occur.
    function automatic logic [4*N-1:0] rand_bus();
        logic [4*N-1:0] b;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(4))
                0:       b[4*(N-1-i) +: 4] = 4'd1;
                1, 2:    b[4*(N-1-i) +: 4] = 4'd3;
                3:       b[4*(N-1-i) +: 4] = 4'd6;
                default: b[4*(N-1-i) +: 4] = 4'd0;
            endcase
        end
        return b;
    endfunction

    task automatic start_capture(input logic [4*N-1:0] b);
        @(negedge clk);
        pat_valid = 1'b1;
        pat_bus   = b;
    endtask

    // n counts cycles after the capture edge; exp_lat < 0 skips the latency check.
    task automatic wait_done(input string tag, input int n0, input int exp_lat,
                             input int pause_at, input int inj_at, input bit rand_run);
        int n;
        n = n0;
        forever begin
            @(negedge clk);
            n++;
            if (n == 1) pat_valid = 1'b0;
            if (rand_run) run = ($urandom_range(3) != 0);
            if (pause_at > 0) begin
                if (n == pause_at) run = 1'b0;
                if (n == pause_at + 10) run = 1'b1;
                if (n >= pause_at && n <= pause_at + 10) chk({tag, "_pause_coil"}, 32'(coil), 32'd4);
            end
            if (inj_at > 0) begin
                if (n == inj_at) begin
                    pat_valid = 1'b1;
                    pat_bus   = rand_bus();
                end
                if (n == inj_at + 1) pat_valid = 1'b0;
            end
            if (done === 1'b1) break;
            if (n > 3000) begin
                chk({tag, "_timeout"}, 32'(n), 32'(exp_lat));
                run = 1'b1;
                return;
            end
        end
        run = 1'b1;
        $display("%s: done after %0d cycles", tag, n);
        if (exp_lat >= 0) chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    initial begin
        rst       = 1'b1;
        pat_valid = 1'b0;
        run       = 1'b1;
        pat_bus   = '0;

        repeat (3) @(negedge clk);
        chk("rst_coil", 32'(coil), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_idx",  32'(step_idx), 32'd0);
        #2 rst = 1'b0;
        chk_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        $display("reset: coil=%0d busy=%0d", coil, busy);

        start_capture(wave_bus());
        wait_done("wave", 0, N*SC + (N-1)*DC + 1, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        chk("wave_coil_after", 32'(coil), 32'd0);

        start_capture(const_bus(4'd3));
        wait_done("const3", 0, N*SC + 1, 0, 0, 1'b0);

        // Pause while the 4 pattern of the seventh entry is driven (cycles 31..33).
        start_capture(wave_bus());
        wait_done("pause", 0, N*SC + (N-1)*DC + 1 + 10, 32, 0, 1'b0);

        // A capture strobe mid-sequence is ignored; one held across DONE lands in IDLE.
        start_capture(wave_bus());
        wait_done("inject", 0, N*SC + (N-1)*DC + 1, 0, 40, 1'b0);
        pat_valid = 1'b1;
        pat_bus   = const_bus(4'd3);
        @(negedge clk);
        chk("done_pv_ignored", 32'(busy), 32'd0);
        @(negedge clk);
        pat_valid = 1'b0;
        chk("idle_pv_busy", 32'(busy), 32'd1);
        chk("idle_pv_coil", 32'(coil), 32'd3);
        wait_done("after_done", 1, N*SC + 1, 0, 0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            start_capture(rand_bus());
            wait_done("random", 0, -1, 0, 0, 1'b1);
            repeat ($urandom_range(3)) @(negedge clk);
        end

        // Abandon a sequence in the middle of a dead-time gap.
        start_capture(wave_bus());
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            pat_valid = 1'b0;
            #1;
            if (exp_busy && exp_coil == 4'd0 && n > 20) break;
        end
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_coil", 32'(coil), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_idx",  32'(step_idx), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no_done_after_rst", 32'(done), 32'd0);
        end
        start_capture(wave_bus());
        @(negedge clk);
        pat_valid = 1'b0;
        chk("replay_idx",  32'(step_idx), 32'd0);
        chk("replay_coil", 32'(coil), 32'd1);
        wait_done("replay", 1, N*SC + (N-1)*DC + 1, 0, 0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
